// File: rtl/cv32e40p_sleep_ctrl_multi.sv
// ---------------------------------------------------------------------------
// cv32e40p_sleep_ctrl_multi
//
// Multi-domain sleep controller. It sequences a WFI-style sleep through a
// drain phase with programmable idle hysteresis. It drives one
// cv32e40p_clock_gate per clock domain. It wakes on any enabled wake source
// and reports which sources caused the wake. The FSM runs on the free-running
// clock. Domain 0 is the controller domain and stays clocked while draining.
//
// Optional feature: define CV32E40P_SLEEP_STATS_EN to add sleep statistics
// counters (sleep_cycles_o, sleep_entries_o).
//
// Ports:
//   clk_ungated_i   in   free-running clock, the only clock
//   rst_i           in   synchronous active-high reset
//   scan_cg_en_i    in   forces every clock gate on (test)
//   fetch_enable_i  in   fetch enable, made sticky internally
//   fetch_enable_o  out  sticky fetch enable
//   sleep_req_i     in   level sleep request (WFI)
//   dom_busy_i      in   per-domain busy
//   wake_i          in   raw wake sources
//   wake_mask_i     in   wake source enables (1 = enabled)
//   idle_thresh_i   in   idle cycles required before sleeping
//   clk_gated_o     out  per-domain gated clocks
//   core_sleep_o    out  core is asleep
//   wake_src_o      out  masked wake sources captured at wake
//   wake_valid_o    out  one-cycle pulse in the first WAKE cycle
//   sleep_cycles_o  out  (stats only) cycles spent with core_sleep_o=1, saturating
//   sleep_entries_o out  (stats only) DRAIN->SLEEP transitions, wrapping
// ---------------------------------------------------------------------------

// Latch-based clock gate. The enable is captured while the clock is low, so
// the gated clock can never glitch during the high phase.
module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic clk_en;

  always_latch begin
    if (clk_i == 1'b0) clk_en <= en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & clk_en;

endmodule

module cv32e40p_sleep_ctrl_multi #(
  parameter int NUM_DOMAINS = 2,
  parameter int NUM_WAKE    = 4,
  parameter int IDLE_CNT_W  = 4,
  parameter int WAKE_DLY    = 2
) (
  input  logic                   clk_ungated_i,
  input  logic                   rst_i,
  input  logic                   scan_cg_en_i,
  input  logic                   fetch_enable_i,
  output logic                   fetch_enable_o,
  input  logic                   sleep_req_i,
  input  logic [NUM_DOMAINS-1:0] dom_busy_i,
  input  logic [NUM_WAKE-1:0]    wake_i,
  input  logic [NUM_WAKE-1:0]    wake_mask_i,
  input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
  output logic [NUM_DOMAINS-1:0] clk_gated_o,
  output logic                   core_sleep_o,
  output logic [NUM_WAKE-1:0]    wake_src_o,
  output logic                   wake_valid_o
`ifdef CV32E40P_SLEEP_STATS_EN
  ,
  output logic [31:0]            sleep_cycles_o,
  output logic [15:0]            sleep_entries_o
`endif
);

  localparam logic [2:0] OFF   = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] SLEEP = 3'd3;
  localparam logic [2:0] WAKE  = 3'd4;

  // A zero wake delay still needs one WAKE cycle to emit wake_valid_o.
  localparam int WAKE_LEN = (WAKE_DLY < 1) ? 1 : WAKE_DLY;
  localparam int WCNT_W   = (WAKE_LEN > 1) ? $clog2(WAKE_LEN) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_LEN - 1);

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic                   fetch_en_q;
  logic [IDLE_CNT_W-1:0]  idle_cnt_q;
  logic [IDLE_CNT_W-1:0]  idle_cnt_d;
  logic [NUM_DOMAINS-1:0] busy_q;
  logic [WCNT_W-1:0]      wake_cnt_q;
  logic [WCNT_W-1:0]      wake_cnt_d;
  logic [NUM_WAKE-1:0]    wake_src_q;
  logic                   wake_valid_q;
  logic [NUM_WAKE-1:0]    masked_wake;
  logic                   wake_hit;
  logic                   all_idle;
  logic [NUM_DOMAINS-1:0] gate_en;

  assign masked_wake = wake_i & wake_mask_i;
  assign wake_hit    = |masked_wake;
  assign all_idle    = ~|dom_busy_i;

  // Next-state logic. The idle counter is cleared on every DRAIN exit, so
  // each new drain starts its hysteresis from zero. A wake request beats
  // sleep entry when both occur in the same DRAIN cycle.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      OFF: begin
        if (fetch_en_q) state_d = RUN;
      end
      RUN: begin
        if (sleep_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!sleep_req_i || wake_hit) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (all_idle && (idle_cnt_q >= idle_thresh_i)) begin
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else if (!all_idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      SLEEP: begin
        if (wake_hit) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) state_d = RUN;
        else wake_cnt_d = wake_cnt_q + 1'b1;
      end
      default: state_d = OFF;
    endcase
  end

  // Gate enables. While draining, a non-controller domain keeps its clock
  // for one extra cycle after busy drops (busy_q), so its last action can
  // complete. In SLEEP the enables follow wake_hit directly, so clocks
  // resume in the same cycle as the wake.
  always_comb begin
    gate_en = '0;
    if (!rst_i) begin
      case (state_q)
        RUN, WAKE: gate_en = '1;
        DRAIN: begin
          gate_en    = dom_busy_i | busy_q;
          gate_en[0] = 1'b1;
        end
        SLEEP:   gate_en = {NUM_DOMAINS{wake_hit}};
        default: gate_en = '0;
      endcase
    end
  end

  // State registers. In SLEEP without a wake every register holds its value.
  // Once gate_en is zero, the free-running clock can be stopped upstream.
  always_ff @(posedge clk_ungated_i) begin
    if (rst_i) begin
      state_q      <= OFF;
      fetch_en_q   <= 1'b0;
      idle_cnt_q   <= '0;
      busy_q       <= '0;
      wake_cnt_q   <= '0;
      wake_src_q   <= '0;
      wake_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_en_q   <= fetch_en_q | fetch_enable_i;
      idle_cnt_q   <= idle_cnt_d;
      busy_q       <= dom_busy_i;
      wake_cnt_q   <= wake_cnt_d;
      wake_valid_q <= (state_q == SLEEP) && wake_hit;
      if ((state_q == SLEEP) && wake_hit) wake_src_q <= masked_wake;
    end
  end

  assign fetch_enable_o = fetch_en_q;
  assign core_sleep_o   = !rst_i && (state_q == SLEEP) && !wake_hit;
  assign wake_src_o     = wake_src_q;
  assign wake_valid_o   = wake_valid_q;

`ifdef CV32E40P_SLEEP_STATS_EN
  logic [31:0] sleep_cycles_q;
  logic [15:0] sleep_entries_q;

  // Sleep statistics. The cycle counter saturates and the entry counter wraps.
  always_ff @(posedge clk_ungated_i) begin
    if (rst_i) begin
      sleep_cycles_q  <= '0;
      sleep_entries_q <= '0;
    end else begin
      if (core_sleep_o && (sleep_cycles_q != '1)) sleep_cycles_q <= sleep_cycles_q + 1'b1;
      if ((state_q == DRAIN) && (state_d == SLEEP)) sleep_entries_q <= sleep_entries_q + 1'b1;
    end
  end

  assign sleep_cycles_o  = sleep_cycles_q;
  assign sleep_entries_o = sleep_entries_q;
`endif

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_gate
    cv32e40p_clock_gate u_gate (
      .clk_i        (clk_ungated_i),
      .en_i         (gate_en[d]),
      .scan_cg_en_i (scan_cg_en_i),
      .clk_o        (clk_gated_o[d])
    );
  end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_sleep_ctrl_multi
//
// Directed testbench for cv32e40p_sleep_ctrl_multi using the default
// parameters (2 domains, 4 wake sources, 4-bit idle counter, WAKE_DLY=2).
// Gated clock activity is observed by counting rising edges per domain.
// An edge at a clock posedge reflects the enable of the cycle just completed.
// ---------------------------------------------------------------------------
module tb_cv32e40p_sleep_ctrl_multi;

  logic       clock = 1'b0;
  logic       rstIn;
  logic       scanEn;
  logic       fetchIn;
  logic       sleepReq;
  logic [1:0] domBusy;
  logic [3:0] wakeIn;
  logic [3:0] wakeMask;
  logic [3:0] idleThresh;

  logic       fetchOut;
  logic [1:0] clkGated;
  logic       coreSleep;
  logic [3:0] wakeSrc;
  logic       wakeValid;
`ifdef CV32E40P_SLEEP_STATS_EN
  logic [31:0] sleepCycles;
  logic [15:0] sleepEntries;
`endif

  int total = 0;
  int bad   = 0;
  int gateCount0 = 0;
  int gateCount1 = 0;
  int base0 = 0;
  int base1 = 0;

  logic gclk0;
  logic gclk1;
  assign gclk0 = clkGated[0];
  assign gclk1 = clkGated[1];

  cv32e40p_sleep_ctrl_multi dut (
    .clk_ungated_i  (clock),
    .rst_i          (rstIn),
    .scan_cg_en_i   (scanEn),
    .fetch_enable_i (fetchIn),
    .fetch_enable_o (fetchOut),
    .sleep_req_i    (sleepReq),
    .dom_busy_i     (domBusy),
    .wake_i         (wakeIn),
    .wake_mask_i    (wakeMask),
    .idle_thresh_i  (idleThresh),
    .clk_gated_o    (clkGated),
    .core_sleep_o   (coreSleep),
    .wake_src_o     (wakeSrc),
    .wake_valid_o   (wakeValid)
`ifdef CV32E40P_SLEEP_STATS_EN
    ,
    .sleep_cycles_o  (sleepCycles),
    .sleep_entries_o (sleepEntries)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Count rising edges of each gated clock.
  always @(posedge gclk0) gateCount0 = gateCount0 + 1;
  always @(posedge gclk1) gateCount1 = gateCount1 + 1;

  // Single comparison point. Counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive the input vector, then let combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic f, input logic s,
                               input logic [1:0] b, input logic [3:0] w);
    rstIn    = r;
    fetchIn  = f;
    sleepReq = s;
    domBusy  = b;
    wakeIn   = w;
    #1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic markEdges();
    base0 = gateCount0;
    base1 = gateCount1;
  endtask

  task automatic checkEdges(input string tag, input int exp0, input int exp1);
    checkOutput({tag, "_d0"}, gateCount0 - base0, exp0);
    checkOutput({tag, "_d1"}, gateCount1 - base1, exp1);
  endtask

  // Directed sequence: reset, fetch, idle threshold, masked wake, busy
  // hysteresis, simultaneous wake/sleep, scan override, reset while asleep.
  initial begin
    rstIn = 1'b1; fetchIn = 1'b0; sleepReq = 1'b0; domBusy = '0;
    wakeIn = '0; wakeMask = '0; idleThresh = 4'd3; scanEn = 1'b0;
    markEdges();

    // Three reset cycles. fetch_enable_i in the last one is overridden.
    applyStimulus(1, 0, 0, 2'b00, 4'b0000);
    checkOutput("rst_core_sleep", coreSleep, 0);
    tick();
    applyStimulus(1, 0, 0, 2'b00, 4'b0000); tick();
    applyStimulus(1, 1, 0, 2'b00, 4'b0000); tick();
    checkOutput("rst_fetch_o", fetchOut, 0);
    checkOutput("rst_wake_valid", wakeValid, 0);
    checkOutput("rst_wake_src", wakeSrc, 0);
    checkEdges("rst_gates", 0, 0);

    // OFF until a fetch pulse, then RUN one cycle after it is sampled.
    markEdges();
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick();
    checkOutput("off_fetch_o", fetchOut, 0);
    applyStimulus(0, 1, 0, 2'b00, 4'b0000); tick();
    checkOutput("fetch_o_set", fetchOut, 1);
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick();
    checkEdges("off_gates", 0, 0);
    markEdges();
    tick(); tick();
    checkEdges("run_gates", 2, 2);
    checkOutput("fetch_o_sticky", fetchOut, 1);

    // Threshold 3, no busy: four DRAIN cycles, then SLEEP.
    idleThresh = 4'd3;
    markEdges();
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick();
    checkEdges("run_to_drain", 1, 1);
    markEdges();
    tick(); tick(); tick();
    checkOutput("drain3_awake", coreSleep, 0);
    tick();
    checkOutput("sleep_after_4", coreSleep, 1);
    checkEdges("drain_gates", 4, 0);
    markEdges();
    tick();
    checkEdges("sleep_gates", 0, 0);
    checkOutput("sleep_hold", coreSleep, 1);

    // A masked source is ignored. An enabled source wakes in the same cycle.
    wakeMask = 4'b0100;
    applyStimulus(0, 0, 1, 2'b00, 4'b0001);
    checkOutput("masked_comb", coreSleep, 1);
    markEdges(); tick();
    checkEdges("masked_gates", 0, 0);
    checkOutput("masked_valid", wakeValid, 0);
    applyStimulus(0, 0, 1, 2'b00, 4'b0100);
    checkOutput("wake_comb_sleep", coreSleep, 0);
    markEdges(); tick();
    checkEdges("wake_same_cycle", 1, 1);
    checkOutput("wake_valid_pulse", wakeValid, 1);
    checkOutput("wake_src", wakeSrc, 4'b0100);
    checkOutput("wake_core_sleep", coreSleep, 0);

    // Two WAKE cycles, then RUN -> DRAIN -> SLEEP with threshold 0.
    idleThresh = 4'd0;
    applyStimulus(0, 0, 1, 2'b00, 4'b0100); tick();
    checkOutput("wake_valid_once", wakeValid, 0);
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick();
    tick();
    checkOutput("wake_len_two", coreSleep, 0);
    tick();
    checkOutput("thresh0_sleep", coreSleep, 1);
    checkOutput("wake_src_hold", wakeSrc, 4'b0100);

    // Several raw sources, only the enabled ones are captured.
    wakeMask = 4'b0110;
    applyStimulus(0, 0, 0, 2'b00, 4'b1110); tick();
    checkOutput("wake_src_multi", wakeSrc, 4'b0110);
    checkOutput("wake_valid2", wakeValid, 1);
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick(); tick();

    // Busy pulse on domain 1 restarts the hysteresis: SLEEP after six DRAIN cycles.
    idleThresh = 4'd3;
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick();
    markEdges();
    tick();
    applyStimulus(0, 0, 1, 2'b10, 4'b0000); tick();
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick(); tick(); tick();
    checkOutput("busy_delays_sleep", coreSleep, 0);
    tick();
    checkOutput("busy_sleep", coreSleep, 1);
    checkEdges("busy_gates", 6, 2);
    applyStimulus(0, 0, 0, 2'b00, 4'b0100); tick();
    checkOutput("wake_src_third", wakeSrc, 4'b0100);
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick(); tick();

    // Wake and sleep entry in the same DRAIN cycle: wake wins.
    idleThresh = 4'd2;
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick();
    tick(); tick();
    applyStimulus(0, 0, 1, 2'b00, 4'b0010); tick();
    applyStimulus(0, 0, 0, 2'b00, 4'b0000);
    checkOutput("simul_no_sleep", coreSleep, 0);
    markEdges(); tick();
    checkEdges("simul_run", 1, 1);
    checkOutput("simul_no_valid", wakeValid, 0);

    // The idle counter was cleared on that exit: threshold 1 needs two DRAIN cycles.
    idleThresh = 4'd1;
    applyStimulus(0, 0, 1, 2'b00, 4'b0000); tick();
    tick();
    checkOutput("cnt_cleared", coreSleep, 0);
    tick();
    checkOutput("thresh1_sleep", coreSleep, 1);

    // Scan forces the gates on without disturbing the FSM.
    scanEn = 1'b1;
    markEdges(); tick();
    checkEdges("scan_gates", 1, 1);
    checkOutput("scan_fsm", coreSleep, 1);
    scanEn = 1'b0;
    markEdges(); tick();
    checkEdges("scan_off", 0, 0);

`ifdef CV32E40P_SLEEP_STATS_EN
    checkOutput("stat_entries", sleepEntries, 4);
    checkOutput("stat_cycles", sleepCycles, 4);
`endif

    // Reset while asleep: OFF, fetch cleared, clocks stay off until a new fetch.
    applyStimulus(1, 0, 0, 2'b00, 4'b0000);
    checkOutput("rst_sleep_comb", coreSleep, 0);
    markEdges(); tick();
    checkOutput("rst_fetch_cleared", fetchOut, 0);
    checkOutput("rst_wake_src2", wakeSrc, 0);
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick(); tick();
    checkOutput("off_no_sleep", coreSleep, 0);
    checkEdges("off_after_rst", 0, 0);
`ifdef CV32E40P_SLEEP_STATS_EN
    checkOutput("stat_entries_rst", sleepEntries, 0);
    checkOutput("stat_cycles_rst", sleepCycles, 0);
`endif
    applyStimulus(0, 1, 0, 2'b00, 4'b0000); tick();
    applyStimulus(0, 0, 0, 2'b00, 4'b0000); tick();
    markEdges(); tick();
    checkEdges("refetch_run", 1, 1);
    checkOutput("refetch_o", fetchOut, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
